// File: rtl/wb_bus_pkg.sv
// wb_bus_pkg: shared state, master/slave indices and address region decode for the scheduler
package wb_bus_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;
    typedef enum logic [1:0] {M_BOOT, M_DATA, M_INSTR} master_e;
    typedef enum logic [2:0] {S_RAM, S_GPIO, S_TIMER, S_ELUKS, S_NONE} slave_e;
    localparam logic [2:0] REG_RAM   = 3'b000;
    localparam logic [2:0] REG_GPIO  = 3'b010;
    localparam logic [2:0] REG_TIMER = 3'b100;
    localparam logic [2:0] REG_ELUKS = 3'b101;
    function automatic slave_e decode_region(input logic [2:0] region);
        return region == REG_RAM   ? S_RAM   :
               region == REG_GPIO  ? S_GPIO  :
               region == REG_TIMER ? S_TIMER :
               region == REG_ELUKS ? S_ELUKS : S_NONE;
    endfunction
endpackage

// File: rtl/wb_bus_scheduler_grant_rr.sv
// wb_grant_rr: boot-first winner selection with round-robin between data and instruction
module wb_grant_rr
    import wb_bus_pkg::*;
(
    input  logic [2:0] cyc_i,
    input  master_e    last_i,
    output logic       req_o,
    output master_e    win_o
);
    assign req_o = |cyc_i;
    assign win_o = cyc_i[M_BOOT] ? M_BOOT :
                   (cyc_i[M_DATA] && cyc_i[M_INSTR]) ? (last_i == M_DATA ? M_INSTR : M_DATA) :
                   cyc_i[M_DATA] ? M_DATA : M_INSTR;
endmodule

// File: rtl/wb_bus_scheduler.sv
// wb_bus_scheduler: registered Wishbone scheduler granting one master per transaction,
// terminating unmapped and hung accesses with an error response.
module wb_bus_scheduler
    import wb_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDT        = 32'h0000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic [2:0]       m_cyc_i,
    input  logic [2:0]       m_we_i,
    input  logic [2:0][31:0] m_adr_i,
    input  logic [2:0][31:0] m_dat_i,
    input  logic [2:0][3:0]  m_sel_i,
    output logic [2:0]       m_ack_o,
    output logic [2:0][31:0] m_rdt_o,
    output logic [3:0]       s_cyc_o,
    output logic [3:0]       s_we_o,
    output logic [3:0][31:0] s_adr_o,
    output logic [3:0][31:0] s_dat_o,
    output logic [3:0][3:0]  s_sel_o,
    input  logic [3:0][31:0] s_rdt_i,
    input  logic [3:0]       s_ack_i,
    input  logic             err_clr_i,
    output logic             err_timeout_o,
    output logic             err_unmapped_o,
    output logic [31:0]      err_adr_o
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    master_e       mst_q, mst_d, last_q, last_d, win;
    slave_e        slv_q, slv_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_to_q, err_to_d, err_um_q, err_um_d;
    logic [31:0]   err_adr_q, err_adr_d;
    logic          req, mcyc, mapped, sack, tc, ev_to, ev_um;
    logic [1:0]    si;

    wb_grant_rr u_grant (
        .cyc_i  (m_cyc_i),
        .last_i (last_q),
        .req_o  (req),
        .win_o  (win)
    );

    assign si     = slv_q[1:0];
    assign mapped = slv_q != S_NONE;
    assign mcyc   = m_cyc_i[mst_q];
    assign sack   = mapped && s_ack_i[si];
    assign tc     = cnt_q == TC;

    always_comb begin
        state_d = state_q;
        mst_d   = mst_q;
        slv_d   = slv_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ev_to   = 1'b0;
        ev_um   = 1'b0;
        s_cyc_o = '0;
        s_we_o  = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        m_rdt_o = '0;
        case (state_q)
            IDLE: if (req) begin
                state_d = GRANT;
                mst_d   = win;
                slv_d   = decode_region(m_adr_i[win][31:29]);
                cnt_d   = '0;
            end
            GRANT: begin
                if (mapped) begin
                    // a real ack at terminal count keeps cyc up; only a forced timeout drops it
                    s_cyc_o[si] = mcyc && (sack || !tc);
                    s_we_o[si]  = m_we_i[mst_q];
                    s_adr_o[si] = m_adr_i[mst_q];
                    s_dat_o[si] = m_dat_i[mst_q];
                    s_sel_o[si] = m_sel_i[mst_q];
                end
                if (!mcyc) state_d = IDLE;
                else if (!mapped || sack || tc) begin
                    state_d        = RELEASE;
                    m_ack_o[mst_q] = 1'b1;
                    m_rdt_o[mst_q] = sack ? s_rdt_i[si] : ERR_RDT;
                    ev_um          = !mapped;
                    ev_to          = mapped && !sack;
                    if (sack && mst_q != M_BOOT) last_d = mst_q;
                end else cnt_d = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
        err_to_d  = ev_to || (err_to_q && !err_clr_i);
        err_um_d  = ev_um || (err_um_q && !err_clr_i);
        err_adr_d = (ev_to || ev_um) ? m_adr_i[mst_q] : err_clr_i ? 32'h0 : err_adr_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= IDLE;
            mst_q     <= M_BOOT;
            slv_q     <= S_NONE;
            cnt_q     <= '0;
            last_q    <= M_INSTR;
            err_to_q  <= 1'b0;
            err_um_q  <= 1'b0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            mst_q     <= mst_d;
            slv_q     <= slv_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            err_to_q  <= err_to_d;
            err_um_q  <= err_um_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign err_timeout_o  = err_to_q;
    assign err_unmapped_o = err_um_q;
    assign err_adr_o      = err_adr_q;
endmodule

// File: doc/wb_bus_scheduler.md
# wb_bus_scheduler

Registered Wishbone scheduler sharing the SoC slave set (RAM, GPIO, timer, ELUKS) among the boot, data and instruction masters of the SERV subsystem. Replaces the combinational interconnect path with a state machine that grants one master per transaction, holds the grant until ack, and applies round-robin fairness between data and instruction. It also terminates unmapped and hung accesses so a master never stalls indefinitely.

## Interface
- TIMEOUT_CYCLES, 1024: cycles in GRANT without slave ack before the scheduler forces termination; ≥ 2.
- ERR_RDT, 32'h0000_0000: read data returned on unmapped or timed-out access.
- wb_clk  in  1  single clock, rising edge.
- wb_rst_n  in  1  reset, asynchronous assert, active-low.
- boot_bus  whisbone_if.masterconn  —  boot master (highest priority).
- data_bus  whisbone_if.masterconn  —  SERV data master.
- instruction_bus  whisbone_if.masterconn  —  SERV instruction master.
- ram_bus, gpio_bus, timer_bus, eluks_bus  whisbone_if.slaveconn  —  slaves at adr[31:29] = 000, 010, 100, 101.
- err_clr  in  1  clears err_timeout, err_unmapped and err_adr.
- err_timeout  out  1  sticky; set when a timeout termination occurs.
- err_unmapped  out  1  sticky; set when an unmapped access is terminated.
- err_adr  out  32  address of the most recent errored access.

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE: scheduler samples all master wb_cyc. Winner: boot if requesting; else data vs instruction by round-robin. Both requesting: the one not granted last wins. last_grant resets to instruction, so data wins the first tie. Winner index and decoded slave select are registered; go to GRANT.
- GRANT: granted master's adr/dat/sel/we drive the selected slave; slave wb_cyc = granted master wb_cyc. Slave rdt/ack route to granted master. All other master ack = 0, rdt = 0. All other slave cyc = 0.
- Slave ack in GRANT: pass to master in the same cycle; go to RELEASE; update last_grant (data/instruction only).
- Unmapped region (001, 011, 110, 111): no slave cyc. Scheduler asserts master ack with rdt = ERR_RDT in the first GRANT cycle. Sets err_unmapped and loads err_adr. Goes to RELEASE.
- Timeout: cycle counter clears on entering GRANT and increments each GRANT cycle. When it reaches TIMEOUT_CYCLES-1 with no ack, the scheduler forces ack with rdt = ERR_RDT and drops slave cyc in that cycle. Sets err_timeout and loads err_adr. Goes to RELEASE.
- Master drops wb_cyc in GRANT without ack (abort): slave cyc falls the same cycle; no ack; go to IDLE; last_grant unchanged.
- RELEASE: one cycle with no grant and all slave cyc = 0. This absorbs the master's cyc deassertion after ack. Then go to IDLE.
- Simultaneous slave ack and timeout terminal count: slave ack wins; no error flagged.
- Simultaneous err_clr and error event: the new error is recorded (set has priority).
- Slave select and master index are frozen for the whole transaction. Address changes during GRANT do not re-decode.

## Timing
- Reset (async, wb_rst_n low): state IDLE; all slave wb_cyc 0; all master wb_ack 0 and wb_rdt 0; counter 0; last_grant = instruction; err_timeout 0, err_unmapped 0, err_adr 0. Slave adr/dat/sel/we drive 0 when not granted.
- Grant latency: master cyc seen in cycle N; slave cyc asserted in cycle N+1.
- Ack path: slave ack to master ack is combinational, 0 cycles.
- Minimum transaction: IDLE, GRANT (ack), RELEASE, so 3 cycles. Back-to-back requests: next grant decision in the IDLE cycle after RELEASE.
- Unmapped access: ack in cycle N+1.
- Timeout: forced ack in GRANT cycle TIMEOUT_CYCLES (counter value TIMEOUT_CYCLES-1). Counter width $clog2(TIMEOUT_CYCLES); it never wraps.
- Error flags and err_adr update on the clock edge that ends the errored GRANT cycle.
- Reset asserted mid-transaction: outputs go to reset values immediately. There is no ack to the in-flight master.

## Structure
- Package wb_bus_pkg holds:
  - state enum {IDLE, GRANT, RELEASE};
  - master index enum {M_BOOT, M_DATA, M_INSTR};
  - slave index enum and region constants REG_RAM=3'b000, REG_GPIO=3'b010, REG_TIMER=3'b100, REG_ELUKS=3'b101;
  - function decode_region(adr[31:29]) returning slave index or unmapped.
- Sub-module wb_grant_rr: pure priority/round-robin winner selection from the three cyc inputs and last_grant. It is instantiated once and reused by the future multi-core variant.

## Test plan
- Data reads RAM adr 0x0000_0010; RAM acks 2 cycles after its cyc rises. Required: RAM cyc rises in cycle N+1; data ack coincident with RAM ack; rdt = RAM value; RELEASE for 1 cycle.
- Data and instruction request simultaneously, repeatedly, to RAM. Required: grants alternate data, instr, data, instr. Boot raised mid-sequence gets the next grant.
- Instruction fetch to 0x2000_0000 (unmapped). Required: ack in cycle N+1; rdt = 0; err_unmapped = 1; err_adr = 0x2000_0000; no slave cyc.
- Timer never acks; TIMEOUT_CYCLES = 16. Required: forced ack in 16th GRANT cycle; timer cyc low in that cycle; err_timeout = 1. Then pulse err_clr: flags and err_adr return to 0.
- Slave ack arrives exactly at the terminal count. Required: real rdt returned; err_timeout stays 0.
- wb_rst_n low while a GPIO write is in GRANT. Required: gpio cyc and all acks drop immediately. After release, a first tie between data and instruction grants data.
